// File: rtl/ct_lsu_dcache_status_ctrl_if.sv
// Port bundles for ct_lsu_dcache_status_ctrl: the client request/response/flush
// channel and the pin-level bus to the 256x7 dcache status SRAM.

// Handshake: a request transfers on a rising edge where req_vld && req_rdy.
// req_rdy is a function of state and flush_req only, never of req_vld.
// resp_vld is a one-cycle pulse with no back-pressure.
interface ct_lsu_dcache_status_ctrl_if;
    logic       req_vld;
    logic       req_rdy;
    logic       req_wr;
    logic [7:0] req_idx;
    logic [6:0] req_din;
    logic [6:0] req_wmask;
    logic       flush_req;
    logic       flush_done;
    logic       resp_vld;
    logic [6:0] resp_data;

    modport master (
        output req_vld, req_wr, req_idx, req_din, req_wmask, flush_req,
        input  req_rdy, flush_done, resp_vld, resp_data
    );

    modport slave (
        input  req_vld, req_wr, req_idx, req_din, req_wmask, flush_req,
        output req_rdy, flush_done, resp_vld, resp_data
    );
endinterface

interface ct_lsu_dcache_status_sram_if;
    logic [7:0] sram_a;
    logic       sram_cen;
    logic       sram_gwen;
    logic [6:0] sram_wen;
    logic [6:0] sram_d;
    logic [6:0] sram_q;

    // master = controller that owns the control pins, slave = the SRAM macro
    modport master (
        output sram_a, sram_cen, sram_gwen, sram_wen, sram_d,
        input  sram_q
    );

    modport slave (
        input  sram_a, sram_cen, sram_gwen, sram_wen, sram_d,
        output sram_q
    );
endinterface

// File: rtl/ct_lsu_dcache_status_ctrl.sv
// Access controller for the LSU 256x7 dcache status SRAM: clear sweep, reads, masked writes.
// Define CT_LSU_STATUS_RST_INIT_EN to start a clear sweep out of reset.
module ct_lsu_dcache_status_ctrl #(
    parameter logic [6:0] INIT_VAL = 7'h00
) (
    input  logic                               forever_cpuclk,
    input  logic                               cpurst_b,
    ct_lsu_dcache_status_ctrl_if.slave         req,
    ct_lsu_dcache_status_sram_if.master        sram,
    output logic                               dbg_state
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

`ifdef CT_LSU_STATUS_RST_INIT_EN
    localparam state_t RST_STATE = ST_INIT;
`else
    localparam state_t RST_STATE = ST_IDLE;
`endif

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       flush_done_q;
    logic       rd_pend_q;
    logic [6:0] hold_q;

    logic       rdy;
    logic       rd_acc;
    logic       cen;
    logic       gwen;
    logic [6:0] wen;
    logic [7:0] addr;
    logic [6:0] wdata;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q      <= RST_STATE;
            cnt_q        <= 8'h00;
            flush_done_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            hold_q       <= 7'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_done_q <= (state_q == ST_INIT) && (cnt_q == 8'hFF);
            rd_pend_q    <= rd_acc;
            if (rd_pend_q) begin
                hold_q <= sram.sram_q;
            end
        end
    end

    // Idle pins park at cen=1 with a/d zeroed so nothing floats between accesses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy     = 1'b0;
        rd_acc  = 1'b0;
        cen     = 1'b1;
        gwen    = 1'b1;
        wen     = 7'h7F;
        addr    = 8'h00;
        wdata   = 7'h00;
        case (state_q)
            ST_INIT: begin
                cen   = 1'b0;
                gwen  = 1'b0;
                wen   = 7'h00;
                addr  = cnt_q;
                wdata = INIT_VAL;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                rdy = !req.flush_req;
                if (req.flush_req) begin
                    // flush outranks a same-cycle request, which stays unaccepted
                    state_d = ST_INIT;
                    cnt_d   = 8'h00;
                end else if (req.req_vld) begin
                    if (!req.req_wr) begin
                        rd_acc = 1'b1;
                        cen    = 1'b0;
                        addr   = req.req_idx;
                    end else if (req.req_wmask != 7'h00) begin
                        cen   = 1'b0;
                        gwen  = 1'b0;
                        wen   = ~req.req_wmask;
                        addr  = req.req_idx;
                        wdata = req.req_din;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = 8'h00;
            end
        endcase
    end

    assign req.req_rdy    = rdy;
    assign req.flush_done = flush_done_q;
    assign req.resp_vld   = rd_pend_q;
    // sram_q is live only in the response cycle; the hold register covers the rest
    assign req.resp_data  = rd_pend_q ? sram.sram_q : hold_q;

    assign sram.sram_a    = addr;
    assign sram.sram_cen  = cen;
    assign sram.sram_gwen = gwen;
    assign sram.sram_wen  = wen;
    assign sram.sram_d    = wdata;

    assign dbg_state      = state_q;

endmodule

// File: tb/tb_ct_lsu_dcache_status_ctrl.sv
// Self-checking bench for ct_lsu_dcache_status_ctrl with a behavioural 256x7 SRAM.
// Works with or without CT_LSU_STATUS_RST_INIT_EN defined.
module tb_ct_lsu_dcache_status_ctrl;

  localparam logic [6:0] INIT_VAL = 7'h00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ct_lsu_dcache_status_ctrl_if rif ();
  ct_lsu_dcache_status_sram_if sif ();
  logic dbg_state;

  ct_lsu_dcache_status_ctrl #(.INIT_VAL(INIT_VAL)) u_dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .req            (rif),
    .sram           (sif),
    .dbg_state      (dbg_state)
  );

`ifdef CT_LSU_STATUS_RST_INIT_EN
  localparam logic RST_RDY = 1'b0;
  localparam logic RST_ST  = 1'b0;
`else
  localparam logic RST_RDY = 1'b1;
  localparam logic RST_ST  = 1'b1;
`endif

  // ---------------- SRAM model ----------------
  logic [6:0] mem [256];
  logic [6:0] q_r = 7'h00;
  assign sif.sram_q = q_r;

  always @(posedge clk) begin
    if (!sif.sram_cen) begin
      if (!sif.sram_gwen) begin
        for (int b = 0; b < 7; b++) begin
          if (!sif.sram_wen[b]) mem[sif.sram_a][b] <= sif.sram_d[b];
        end
      end else begin
        q_r <= mem[sif.sram_a];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [6:0] shadow [256];
  logic [6:0] exp_q [$];
  int exp_cyc_q [$];
  logic [6:0] mon_e;
  int mon_c;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && rif.resp_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: resp_vld=1 data=%h, no read outstanding", rif.resp_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        if (rif.resp_data !== mon_e || cyc != mon_c) begin
          errors++;
          $display("FAIL resp_data: got %h at cycle %0d, expected %h at cycle %0d",
                   rif.resp_data, cyc, mon_e, mon_c);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Drive one request from posedge+1; check acceptance and SRAM pins at negedge.
  task automatic issue(input logic wr, input logic [7:0] idx, input logic [6:0] din,
                       input logic [6:0] mask);
    logic exp_cen;
    logic [6:0] exp_wen;
    rif.req_vld = 1'b1;
    rif.req_wr = wr;
    rif.req_idx = idx;
    rif.req_din = din;
    rif.req_wmask = mask;
    rif.flush_req = 1'b0;
    @(negedge clk);
    checks++;
    if (rif.req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL req_rdy: got %b, expected 1 (idx %h)", rif.req_rdy, idx);
    end
    exp_cen = wr && (mask == 7'h00);
    checks++;
    if (sif.sram_cen !== exp_cen) begin
      errors++;
      $display("FAIL sram_cen: got %b, expected %b (wr %b idx %h mask %h)", sif.sram_cen, exp_cen, wr, idx, mask);
    end
    if (!exp_cen) begin
      exp_wen = wr ? ~mask : 7'h7F;
      checks++;
      if (sif.sram_a !== idx || sif.sram_gwen !== !wr || sif.sram_wen !== exp_wen ||
          (wr && sif.sram_d !== din)) begin
        errors++;
        $display("FAIL sram_pins: a=%h gwen=%b wen=%h d=%h, expected a=%h gwen=%b wen=%h d=%h",
                 sif.sram_a, sif.sram_gwen, sif.sram_wen, sif.sram_d, idx, !wr, exp_wen, din);
      end
    end
    if (wr) begin
      shadow[idx] = (shadow[idx] & ~mask) | (din & mask);
    end else begin
      exp_q.push_back(shadow[idx]);
      exp_cyc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rif.req_vld = 1'b0;
    rif.flush_req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Assert flush_req (optionally with a competing request) for one cycle.
  task automatic start_flush(input logic with_req);
    rif.flush_req = 1'b1;
    rif.req_vld = with_req;
    rif.req_wr = 1'b0;
    rif.req_idx = 8'h05;
    @(negedge clk);
    checks++;
    if (rif.req_rdy !== 1'b0 || sif.sram_cen !== 1'b1) begin
      errors++;
      $display("FAIL flush_priority: req_rdy=%b sram_cen=%b, expected 0 and 1", rif.req_rdy, sif.sram_cen);
    end
    @(posedge clk);
    #1;
    rif.flush_req = 1'b0;
    rif.req_vld = 1'b0;
  endtask

  // Expects sram_a==0 at the next negedge. Pulses flush_req at sweep index
  // flush_at; returns early (mid-sweep) at index abort_at.
  task automatic check_sweep(input int flush_at, input int abort_at);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      checks++;
      if (rif.req_rdy !== 1'b0 || sif.sram_cen !== 1'b0 || sif.sram_gwen !== 1'b0 ||
          sif.sram_wen !== 7'h00 || sif.sram_a !== 8'(i) || sif.sram_d !== INIT_VAL ||
          rif.flush_done !== 1'b0) begin
        errors++;
        $display("FAIL sweep[%0d]: rdy=%b cen=%b gwen=%b wen=%h a=%h d=%h done=%b, expected 0 0 0 00 %h %h 0",
                 i, rif.req_rdy, sif.sram_cen, sif.sram_gwen, sif.sram_wen, sif.sram_a,
                 sif.sram_d, rif.flush_done, 8'(i), INIT_VAL);
      end
      rif.flush_req = (i == flush_at);
      if (i == abort_at) return;
    end
    rif.flush_req = 1'b0;
    @(negedge clk);
    checks++;
    if (rif.flush_done !== 1'b1 || rif.req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL sweep_done: flush_done=%b req_rdy=%b, expected 1 1", rif.flush_done, rif.req_rdy);
    end
    for (int k = 0; k < 256; k++) shadow[k] = INIT_VAL;
    @(negedge clk);
    checks++;
    if (rif.flush_done !== 1'b0 || sif.sram_cen !== 1'b1) begin
      errors++;
      $display("FAIL sweep_once: flush_done=%b sram_cen=%b, expected 0 1", rif.flush_done, sif.sram_cen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (sif.sram_cen !== 1'b1 || sif.sram_gwen !== 1'b1 || sif.sram_wen !== 7'h7F ||
        sif.sram_a !== 8'h00 || sif.sram_d !== 7'h00) begin
      errors++;
      $display("FAIL %s_sram: cen=%b gwen=%b wen=%h a=%h d=%h, expected 1 1 7f 00 00",
               tag, sif.sram_cen, sif.sram_gwen, sif.sram_wen, sif.sram_a, sif.sram_d);
    end
    checks++;
    if (rif.flush_done !== 1'b0 || rif.resp_vld !== 1'b0 || rif.resp_data !== 7'h00) begin
      errors++;
      $display("FAIL %s_resp: flush_done=%b resp_vld=%b resp_data=%h, expected 0 0 00",
               tag, rif.flush_done, rif.resp_vld, rif.resp_data);
    end
    checks++;
    if (rif.req_rdy !== RST_RDY || dbg_state !== RST_ST) begin
      errors++;
      $display("FAIL %s_rdy: req_rdy=%b state=%b, expected %b %b", tag, rif.req_rdy, dbg_state, RST_RDY, RST_ST);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rif.req_vld = 1'b0;
    rif.req_wr = 1'b0;
    rif.req_idx = 8'h00;
    rif.req_din = 7'h00;
    rif.req_wmask = 7'h00;
    rif.flush_req = 1'b0;
    for (int k = 0; k < 256; k++) begin
      mem[k] = 7'($urandom_range(1, 127));
      shadow[k] = mem[k];
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_init_sweep();
`ifdef CT_LSU_STATUS_RST_INIT_EN
    check_sweep(-1, -1);
`else
    start_flush(1'b0);
    check_sweep(-1, -1);
`endif
    issue(1'b0, 8'h00, 7'h00, 7'h00);
    issue(1'b0, 8'h80, 7'h00, 7'h00);
    issue(1'b0, 8'hFF, 7'h00, 7'h00);
    idle(2);
  endtask

  task automatic test_write_read();
    issue(1'b1, 8'h3C, 7'h55, 7'h7F);
    issue(1'b0, 8'h3C, 7'h00, 7'h00);
    idle(2);
  endtask

  task automatic test_masked_write();
    issue(1'b1, 8'h3C, 7'h2A, 7'h0F);
    issue(1'b0, 8'h3C, 7'h00, 7'h00);
    idle(1);
    // zero-mask write is accepted but must leave the entry untouched
    issue(1'b1, 8'h3C, 7'h7F, 7'h00);
    issue(1'b0, 8'h3C, 7'h00, 7'h00);
    idle(2);
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 8'h01, 7'h11, 7'h7F);
    issue(1'b1, 8'h02, 7'h22, 7'h7F);
    issue(1'b1, 8'h03, 7'h33, 7'h7F);
    issue(1'b1, 8'h04, 7'h44, 7'h7F);
    for (int k = 1; k <= 4; k++) issue(1'b0, 8'(k), 7'h00, 7'h00);
    idle(3);
    @(negedge clk);
    checks++;
    if (rif.resp_vld !== 1'b0 || rif.resp_data !== 7'h44) begin
      errors++;
      $display("FAIL resp_hold: resp_vld=%b resp_data=%h, expected 0 44", rif.resp_vld, rif.resp_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush_with_req();
    logic [6:0] v;
    v = 7'($urandom_range(1, 127));
    issue(1'b1, 8'h07, v, 7'h7F);
    issue(1'b0, 8'h07, 7'h00, 7'h00);
    start_flush(1'b1);
    check_sweep(50, -1);
    issue(1'b0, 8'h07, 7'h00, 7'h00);
    issue(1'b0, 8'h3C, 7'h00, 7'h00);
    idle(2);
  endtask

  task automatic test_reset_mid_sweep();
    issue(1'b1, 8'hC8, 7'h3E, 7'h7F);
    idle(1);
    start_flush(1'b0);
    check_sweep(-1, 100);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifndef CT_LSU_STATUS_RST_INIT_EN
    start_flush(1'b0);
`endif
    check_sweep(-1, -1);
    issue(1'b0, 8'h64, 7'h00, 7'h00);
    issue(1'b0, 8'hC8, 7'h00, 7'h00);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_write_read();
    test_masked_write();
    test_back_to_back();
    test_flush_with_req();
    test_reset_mid_sweep();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL resp_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
